// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with first-word-fall-through or registered read, programmable flags and overflow/underflow pulses
module sync_fifo_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter bit FWFT = 1'b1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic             empty,
  input  logic [AW:0]      prog_full_thresh,
  input  logic [AW:0]      prog_empty_thresh,
  output logic             prog_full,
  output logic             prog_empty,
  output logic [AW:0]      data_count,
  output logic             overflow,
  output logic             underflow
);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  logic wr_ok, rd_ok;
  assign full = count_q == DEPTH_CNT;
  assign empty = count_q == '0;
  assign prog_full = count_q >= prog_full_thresh;
  assign prog_empty = count_q <= prog_empty_thresh;
  assign data_count = count_q;
  assign overflow = overflow_q;
  assign underflow = underflow_q;
  always_comb begin
    wr_ok = wr_en && !full;
    rd_ok = rd_en && !empty;
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = (wr_ok && !rd_ok) ? count_q + 1'b1 :
              (rd_ok && !wr_ok) ? count_q - 1'b1 : count_q;
    overflow_d = wr_en && full;
    underflow_d = rd_en && empty;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= din;
  end
  generate
    if (FWFT) begin : g_fwft
      // head word is masked while empty so stale storage never leaks out
      assign valid = !empty;
      assign dout = empty ? '0 : mem[rd_ptr_q];
    end else begin : g_std
      logic [WIDTH-1:0] dout_q, dout_d;
      logic valid_q, valid_d;
      always_comb begin
        dout_d = rd_ok ? mem[rd_ptr_q] : dout_q;
        valid_d = rd_ok;
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q <= '0;
          valid_q <= 1'b0;
        end else begin
          dout_q <= dout_d;
          valid_q <= valid_d;
        end
      end
      assign dout = dout_q;
      assign valid = valid_q;
    end
  endgenerate
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: drives an FWFT and a registered-read FIFO with identical stimulus against a queue model
module tb_sync_fifo_param;
  localparam int W = 8;
  localparam int D = 16;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;
  logic [W-1:0] din = '0;
  logic [AW:0] pft = 5'd14;
  logic [AW:0] pet = 5'd2;
  logic [W-1:0] dout_f, dout_s;
  logic valid_f, full_f, empty_f, pf_f, pe_f, ovf_f, udf_f;
  logic valid_s, full_s, empty_s, pf_s, pe_s, ovf_s, udf_s;
  logic [AW:0] cnt_f, cnt_s;
  always #5 clk = ~clk;
  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .FWFT(1'b1)) u_f (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout_f), .valid(valid_f), .full(full_f), .empty(empty_f),
    .prog_full_thresh(pft), .prog_empty_thresh(pet), .prog_full(pf_f), .prog_empty(pe_f),
    .data_count(cnt_f), .overflow(ovf_f), .underflow(udf_f));
  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .FWFT(1'b0)) u_s (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout_s), .valid(valid_s), .full(full_s), .empty(empty_s),
    .prog_full_thresh(pft), .prog_empty_thresh(pet), .prog_full(pf_s), .prog_empty(pe_s),
    .data_count(cnt_s), .overflow(ovf_s), .underflow(udf_s));
  int n_chk = 0;
  int n_fail = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] exp_s[$];
  logic [W-1:0] last_s = '0;
  bit e_ovf = 1'b0;
  bit e_udf = 1'b0;
  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // reference model: a plain queue of stored words, updated at each rising edge
  initial forever begin
    bit fm, em;
    @(posedge clk);
    if (rst_n) begin
      fm = q.size() == D;
      em = q.size() == 0;
      e_ovf = wr_en && fm;
      e_udf = rd_en && em;
      if (rd_en && !em) exp_s.push_back(q.pop_front());
      if (wr_en && !fm) q.push_back(din);
    end
  end
  initial forever begin
    @(negedge rst_n);
    q.delete();
    exp_s.delete();
    last_s = '0;
    e_ovf = 1'b0;
    e_udf = 1'b0;
  end
  // monitor: compares both DUTs against the model away from the rising edge
  initial forever begin
    int n;
    @(negedge clk);
    n = q.size();
    chk("count_f", int'(cnt_f), n);
    chk("count_s", int'(cnt_s), n);
    chk("full_f", full_f, n == D);
    chk("full_s", full_s, n == D);
    chk("empty_f", empty_f, n == 0);
    chk("empty_s", empty_s, n == 0);
    chk("prog_full_f", pf_f, n >= int'(pft));
    chk("prog_full_s", pf_s, n >= int'(pft));
    chk("prog_empty_f", pe_f, n <= int'(pet));
    chk("prog_empty_s", pe_s, n <= int'(pet));
    chk("overflow_f", ovf_f, e_ovf);
    chk("overflow_s", ovf_s, e_ovf);
    chk("underflow_f", udf_f, e_udf);
    chk("underflow_s", udf_s, e_udf);
    chk("valid_f", valid_f, n > 0);
    if (n > 0) chk("dout_f", int'(dout_f), int'(q[0]));
    else chk("dout_f_empty", int'(dout_f), 0);
    if (valid_s) begin
      chk("valid_s_expected", exp_s.size() > 0, 1);
      if (exp_s.size() > 0) begin
        last_s = exp_s.pop_front();
        chk("dout_s", int'(dout_s), int'(last_s));
      end
    end else begin
      chk("valid_s_missing", exp_s.size(), 0);
      chk("dout_s_hold", int'(dout_s), int'(last_s));
    end
  end
  task automatic step(bit w, logic [W-1:0] d, bit r);
    wr_en = w;
    din = d;
    rd_en = r;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int wp;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0);
    for (int i = 0; i < 16; i++) step(1, W'(i), 0);
    step(1, 8'hAA, 0);
    step(0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    step(1, 8'h5A, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    for (int i = 0; i < 16; i++) step(1, W'(8'hE0 + i), 0);
    step(1, 8'h77, 1);
    repeat (15) step(0, 0, 1);
    step(1, 8'h33, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    for (int i = 0; i < 40; i++) step(1, W'(8'h40 + i), i >= 3);
    repeat (4) step(0, 0, 1);
    pft = 5'd12;
    pet = 5'd3;
    for (int i = 0; i < 13; i++) step(1, W'(8'h90 + i), 0);
    repeat (11) step(0, 0, 1);
    repeat (7) step(1, 8'h5C, 0);
    step(0, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_count_f", int'(cnt_f), 0);
    chk("rst_async_count_s", int'(cnt_s), 0);
    chk("rst_async_empty_f", empty_f, 1);
    chk("rst_async_empty_s", empty_s, 1);
    chk("rst_async_valid_s", valid_s, 0);
    chk("rst_async_dout_s", int'(dout_s), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 8'hC3, 0);
    step(1, 8'h3C, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    for (int k = 0; k < 800; k++) begin
      if (k % 100 == 0) begin
        wp = $urandom_range(15, 85);
        pft = AW'(0) + 5'($urandom_range(0, 16));
        pet = 5'($urandom_range(0, 16));
      end
      step($urandom_range(0, 99) < wp, W'($urandom), $urandom_range(0, 99) >= wp);
    end
    repeat (18) step(0, 0, 1);
    step(0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
